// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: timing defaults, host-transmit FSM states and parity helper.
package ps2_pkg;

  localparam int unsigned SYSTEM_CLOCK       = 25_000_000;
  localparam int unsigned INHIBIT_CYCLES_DEF = 2500;
  localparam int unsigned START_TIMEOUT_DEF  = 375000;
  localparam int unsigned FRAME_TIMEOUT_DEF  = 50000;
  localparam int unsigned TIMER_W            = 19;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_WAIT_DEV,
    ST_SEND,
    ST_RELEASE,
    ST_FAIL
  } tx_state_t;

  // PS/2 frames carry odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake and status signals between the host logic and ps2_host_tx.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       error;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, done, error
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, done, error
  );
endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchronisers for the PS/2 clock and data pins plus clock falling-edge detect.
module ps2_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  output logic clk_s,
  output logic data_s,
  output logic clk_fe
);
  logic [1:0] clk_sync;
  logic [1:0] data_sync;
  logic       clk_prev;

  // Idle bus is high; resetting to 1 avoids a false edge after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_in};
      data_sync <= {data_sync[0], ps2_data_in};
      clk_prev  <= clk_sync[1];
    end
  end

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];
  assign clk_fe = clk_prev & ~clk_sync[1];
endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter with request-to-send, ACK check and timeouts.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
  parameter int unsigned START_TIMEOUT  = START_TIMEOUT_DEF,
  parameter int unsigned FRAME_TIMEOUT  = FRAME_TIMEOUT_DEF
) (
  input  logic           clk,
  input  logic           reset,
  ps2_host_tx_if.slave   tx,
  input  logic           ps2_clk_in,
  input  logic           ps2_data_in,
  output logic           ps2_clk_oe,
  output logic           ps2_data_oe
);
  localparam logic [TIMER_W-1:0] INH_LAST = TIMER_W'(INHIBIT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] STA_LAST = TIMER_W'(START_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] FRM_LAST = TIMER_W'(FRAME_TIMEOUT - 1);

  tx_state_t          state, state_d;
  logic [TIMER_W-1:0] timer, timer_d;
  logic [3:0]         bitcnt, bitcnt_d;
  logic [7:0]         shift, shift_d;
  logic               par, par_d;
  logic               clk_oe_d, data_oe_d;
  logic               clk_s, data_s, clk_fe;
  logic               done_c;

  ps2_line_sync u_sync (
    .clk         (clk),
    .reset       (reset),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .clk_s       (clk_s),
    .data_s      (data_s),
    .clk_fe      (clk_fe)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      timer       <= '0;
      bitcnt      <= '0;
      shift       <= '0;
      par         <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
    end else begin
      state       <= state_d;
      timer       <= timer_d;
      bitcnt      <= bitcnt_d;
      shift       <= shift_d;
      par         <= par_d;
      ps2_clk_oe  <= clk_oe_d;
      ps2_data_oe <= data_oe_d;
    end
  end

  // The oe registers are loaded with the value belonging to the next state,
  // so the pins follow the state register without any pin-to-oe path.
  always_comb begin
    state_d   = state;
    timer_d   = timer;
    bitcnt_d  = bitcnt;
    shift_d   = shift;
    par_d     = par;
    clk_oe_d  = 1'b0;
    data_oe_d = 1'b0;
    done_c    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (tx.tx_valid) begin
          state_d  = ST_INHIBIT;
          timer_d  = '0;
          bitcnt_d = '0;
          shift_d  = tx.tx_data;
          par_d    = odd_parity(tx.tx_data);
          clk_oe_d = 1'b1;
        end
      end
      ST_INHIBIT: begin
        clk_oe_d = 1'b1;
        if (timer == INH_LAST) begin
          state_d   = ST_REQ;
          timer_d   = '0;
          data_oe_d = 1'b1;
        end else begin
          timer_d = timer + 1'b1;
        end
      end
      ST_REQ: begin
        state_d   = ST_WAIT_DEV;
        timer_d   = '0;
        data_oe_d = 1'b1;
      end
      ST_WAIT_DEV: begin
        data_oe_d = 1'b1;
        if (clk_fe) begin
          state_d   = ST_SEND;
          timer_d   = '0;
          bitcnt_d  = 4'd1;
          data_oe_d = ~shift[0];
        end else if (timer == STA_LAST) begin
          state_d   = ST_FAIL;
          data_oe_d = 1'b0;
        end else begin
          timer_d = timer + 1'b1;
        end
      end
      ST_SEND: begin
        data_oe_d = ps2_data_oe;
        timer_d   = timer + 1'b1;
        if (clk_fe) begin
          bitcnt_d = bitcnt + 1'b1;
          if (bitcnt <= 4'd7) begin
            data_oe_d = ~shift[bitcnt[2:0]];
          end else if (bitcnt == 4'd8) begin
            data_oe_d = ~par;
          end else if (bitcnt == 4'd9) begin
            data_oe_d = 1'b0;
          end else begin
            data_oe_d = 1'b0;
            state_d   = data_s ? ST_FAIL : ST_RELEASE;
          end
        end else if (timer == FRM_LAST) begin
          state_d   = ST_FAIL;
          data_oe_d = 1'b0;
        end
      end
      ST_RELEASE: begin
        timer_d = timer + 1'b1;
        if (clk_s && data_s) begin
          state_d = ST_IDLE;
          done_c  = 1'b1;
        end else if (timer == FRM_LAST) begin
          state_d = ST_FAIL;
        end
      end
      ST_FAIL: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign tx.tx_ready = (state == ST_IDLE);
  assign tx.busy     = (state != ST_IDLE);
  assign tx.done     = done_c;
  assign tx.error    = (state == ST_FAIL);
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. Sends one command byte, e.g. 0xFF reset, 0xED LEDs or 0xF4 enable, to a keyboard or mouse using the standard request-to-send sequence.
- Drives the shared PS/2 clock/data lines through open-drain enables and checks the device ACK bit.
- Sits beside ps2_decoder on the same pins. `busy` lets the top level hold the decoder in reset while a frame is sent.

Parameters:
- INHIBIT_CYCLES, 2500: clk cycles the host holds ps2_clk low (100 us at 25 MHz).
- START_TIMEOUT, 375000: max cycles from releasing ps2_clk to the device's first falling edge (15 ms).
- FRAME_TIMEOUT, 50000: max cycles from the first falling edge to ACK (2 ms).

Ports:
- clk  in  1  system clock, 25 MHz.
- reset  in  1  asynchronous, active-high.
- tx_data  in  8  command byte.
- tx_valid  in  1  request to send tx_data.
- tx_ready  out  1  high only in IDLE; a byte is accepted on tx_valid && tx_ready.
- ps2_clk_in  in  1  raw PS/2 clock pin level (asynchronous).
- ps2_data_in  in  1  raw PS/2 data pin level (asynchronous).
- ps2_clk_oe  out  1  1 = pull PS/2 clock low.
- ps2_data_oe  out  1  1 = pull PS/2 data low.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the device has ACKed and released the bus.
- error  out  1  one-cycle pulse on NACK or timeout.

Behaviour:
- Reset values:
  - State IDLE; all counters 0.
  - ps2_clk_oe=0, ps2_data_oe=0, busy=0, done=0, error=0, tx_ready=1.
- Input sync and edge detect:
  - ps2_clk_in and ps2_data_in pass through 2-flop synchronisers.
  - A falling edge (fe) is a synced clock of 1 on the previous cycle and 0 now.
- Byte capture:
  - On accept, tx_data is latched into shift[7:0].
  - Odd parity is computed: par = ~^tx_data.
- Counters: one 19-bit timer and one 4-bit bit counter.
- States and transitions:
  - IDLE: on accept go to INHIBIT; timer := 0.
  - INHIBIT:
    - clk_oe=1, data_oe=0.
    - Stays exactly INHIBIT_CYCLES cycles, then goes to REQ.
  - REQ: clk_oe=1, data_oe=1 for exactly one cycle (start bit 0), then WAIT_DEV; timer := 0.
  - WAIT_DEV:
    - clk_oe=0, data_oe=1.
    - On fe: drive bit0 (data_oe = ~shift[0]), bitcnt := 1, timer := 0, go to SEND.
    - If timer reaches START_TIMEOUT first: go to FAIL.
  - SEND: on each fe:
    - bitcnt 1..7: drive bit[bitcnt].
    - bitcnt 8: drive parity (data_oe = ~par).
    - bitcnt 9: release data (stop bit 1).
    - bitcnt 10: sample synced data. 0 -> go to RELEASE; 1 -> go to FAIL.
    - Each driven value holds until the next fe.
    - bitcnt increments on each fe.
  - RELEASE: both oe=0; wait until synced clk=1 and synced data=1, then go to IDLE with done=1 for one cycle.
  - FAIL: both oe=0; error=1 for one cycle, then go to IDLE.
  - Frame timeout: from SEND entry, if timer reaches FRAME_TIMEOUT before ACK, go to FAIL. This also applies in RELEASE.
- Outputs:
  - Open-drain outputs are registered; no combinational path from the pins to the oe outputs.
  - The line is never driven high.
- Boundary conditions:
  - tx_valid while busy is ignored; no queuing.
  - tx_valid held high re-accepts only after returning to IDLE. The earliest next accept is the cycle after done/error.
  - done and error are mutually exclusive and never coincide with tx_ready=0→1 missing: IDLE is entered in the same cycle as the pulse.
  - Reset mid-frame: all oe deassert immediately (async), the frame is abandoned, and no done/error pulse is produced.
  - A glitch on ps2_clk narrower than 2 clk cycles may be missed; this is acceptable.
  - Devices clock at 10–16.7 kHz, so at least 1500 clk cycles per PS/2 bit; no back-to-back fe handling is needed.

Decomposition:
- Shared package ps2_pkg:
  - State encoding localparams.
  - SYSTEM_CLOCK, PS2 timing constants (INHIBIT/START/FRAME defaults).
  - Odd-parity function, also usable by ps2_decoder.
- One natural sub-module: ps2_line_sync (2-flop synchroniser plus falling-edge detect for clk and data). It is reusable by ps2_decoder later.

Test Plan:
- Device model ACKs; send 0xF4:
  - clk_oe low for 2500 cycles, then data_oe=1.
  - Device samples bits 0,0,1,0,1,1,1,1, parity 0, stop 1.
  - ACK 0 -> done pulse once; busy falls; error stays 0.
- Send 0xFF and then 0x00: parity bit sampled = 1 both times, done each time; tx_ready re-asserts between them.
- Device model drives 1 at the ACK slot (NACK) on byte 0xED: error pulse, no done, both oe=0 afterwards.
- Device never clocks after the request: error after exactly START_TIMEOUT cycles in WAIT_DEV; clk_oe and data_oe released.
- Assert reset after the 4th falling edge of a 0xED frame:
  - oe outputs go 0 in the same cycle; no done/error.
  - The next 0x01 transfer completes normally.
- Pulse tx_valid with 0xAA while busy during a 0xF4 frame: the bits on the wire remain 0xF4; 0xAA is never sent.
